// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NUM_REQ
// requesters, with a single registered write stage that can be stalled.
module regfile_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31,
    parameter int SRC_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wr_stall,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [SRC_W-1:0]          wr_src
);

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic [SRC_W-1:0]  wr_src_reg;
    logic [SRC_W-1:0]  rr_ptr_reg;

    logic              adv;
    logic              any_valid;
    logic              grant_en;
    logic [SRC_W-1:0]  winner;
    logic [SRC_W-1:0]  cand;

    assign adv       = ~wr_en_reg | ~wr_stall;
    assign any_valid = |req_valid;
    // rst_n gates the grant so no requester is handshaken while reset is held.
    assign grant_en  = rst_n & adv & any_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = grant_en & (winner == SRC_W'(gi)) & req_valid[gi];
        end
    endgenerate

    // Scan from the farthest candidate back to rr_ptr so the last hit wins;
    // the index wraps naturally because NUM_REQ is a power of two.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = rr_ptr_reg + SRC_W'(k);
            if (req_valid[cand]) begin
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            wr_src_reg  <= '0;
            rr_ptr_reg  <= '0;
        end else if (adv) begin
            if (any_valid) begin
                wr_src_reg  <= winner;
                wr_addr_reg <= addr_arr[winner];
                wr_data_reg <= data_arr[winner];
                // Writes to the hardwired-zero register are accepted but dropped.
                wr_en_reg   <= (addr_arr[winner] != ADDR_W'(ZERO_REG));
                rr_ptr_reg  <= winner + SRC_W'(1);
            end else begin
                wr_en_reg <= 1'b0;
            end
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign wr_src  = wr_src_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against an
// arithmetic round-robin reference model.
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int ZR = 31;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              wr_stall = 1'b0;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [SW-1:0]     wr_src;

    regfile_write_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ZERO_REG(ZR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wr_stall(wr_stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // requester-side view
    logic [AW-1:0] a_q [N];
    logic [DW-1:0] d_q [N];

    // reference model state
    int            m_ptr;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_win;
    logic          m_adv;
    logic [N-1:0]  m_ready;

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = a_q[i];
            req_data[i*DW +: DW] = d_q[i];
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_src = 0;
    endtask

    // Who should be granted now: first valid requester counting up from the pointer.
    task automatic model_eval();
        m_adv = !m_en || !wr_stall;
        m_win = -1;
        for (int k = 0; k < N; k++) begin
            if (m_win < 0 && req_valid[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        end
        m_ready = '0;
        if (rst_n && m_adv && m_win >= 0) m_ready[m_win] = 1'b1;
    endtask

    task automatic model_clock();
        if (m_adv) begin
            if (m_win >= 0) begin
                m_src  = m_win;
                m_addr = a_q[m_win];
                m_data = d_q[m_win];
                m_en   = (int'(a_q[m_win]) != ZR);
                m_ptr  = (m_win + 1) % N;
            end else begin
                m_en = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin a_q[i] = AW'(i + 1); d_q[i] = DW'(64'h100 + i); end
        pack();
        model_reset();
        @(posedge clk); #1;
        total++;
        if (req_ready !== 4'b0000 || wr_en !== 1'b0) begin
            bad++; $display("FAIL reset_hold: ready=%b wr_en=%b required ready=0000 wr_en=0", req_ready, wr_en);
        end
        total++;
        if ({wr_addr, wr_data, wr_src} !== '0) begin
            bad++; $display("FAIL reset_regs: addr=%0d data=%h src=%0d required all zero", wr_addr, wr_data, wr_src);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL reset_first_grant: ready=%b required=0001", req_ready);
        end
        $display("reset: ready after release=%b", req_ready);
        req_valid = '0;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_rr_sequence();
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            #1; model_eval();
            total++;
            if (req_ready !== m_ready) begin
                bad++; $display("FAIL rr_ready cyc%0d: ready=%b required=%b", c, req_ready, m_ready);
            end
            tick();
            total++;
            if (wr_en !== 1'b1 || int'(wr_src) != (c % N)) begin
                bad++; $display("FAIL rr_seq cyc%0d: wr_en=%b src=%0d required wr_en=1 src=%0d", c, wr_en, wr_src, c % N);
            end
            $display("rr cyc%0d: src=%0d addr=%0d", c, wr_src, wr_addr);
        end
        req_valid = '0;
        #1; model_eval(); tick();
    endtask

    task automatic test_single();
        a_q[2] = 5'd5; d_q[2] = 64'hDEAD_BEEF; pack();
        req_valid = 4'b0100;
        #1; model_eval();
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL single_ready: ready=%b required=0100", req_ready);
        end
        tick();
        req_valid = '0;
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'hDEAD_BEEF || wr_src !== 2'd2) begin
            bad++; $display("FAIL single_write: en=%b addr=%0d data=%h src=%0d required 1/5/deadbeef/2",
                            wr_en, wr_addr, wr_data, wr_src);
        end
        $display("single: en=%b addr=%0d data=%h src=%0d", wr_en, wr_addr, wr_data, wr_src);
        #1; model_eval(); tick();
    endtask

    task automatic test_zero_reg();
        a_q[1] = 5'd31; d_q[1] = 64'h1234; pack();
        req_valid = 4'b0010;
        #1; model_eval();
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL zero_ready: ready=%b required=0010", req_ready);
        end
        tick();
        total++;
        if (wr_en !== 1'b0 || wr_src !== 2'd1) begin
            bad++; $display("FAIL zero_drop: wr_en=%b src=%0d required wr_en=0 src=1", wr_en, wr_src);
        end
        a_q[1] = 5'd7; a_q[2] = 5'd9; pack();
        req_valid = 4'b0110;
        #1; model_eval();
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL zero_ptr_adv: ready=%b required=0100", req_ready);
        end
        $display("zero_reg: next ready=%b", req_ready);
        tick();
        req_valid = '0;
        #1; model_eval(); tick();
    endtask

    task automatic test_stall();
        logic [AW+DW+SW:0] snap;
        a_q[0] = 5'd3; d_q[0] = 64'hA0; a_q[3] = 5'd4; d_q[3] = 64'hA3; pack();
        req_valid = 4'b0001;
        #1; model_eval(); tick();
        snap = {wr_en, wr_addr, wr_data, wr_src};
        wr_stall = 1'b1;
        req_valid = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            #1; model_eval();
            total++;
            if (req_ready !== 4'b0000) begin
                bad++; $display("FAIL stall_ready cyc%0d: ready=%b required=0000", c, req_ready);
            end
            tick();
            total++;
            if ({wr_en, wr_addr, wr_data, wr_src} !== snap || wr_en !== 1'b1) begin
                bad++; $display("FAIL stall_frozen cyc%0d: out=%h required=%h", c, {wr_en, wr_addr, wr_data, wr_src}, snap);
            end
            $display("stall cyc%0d: ready=%b en=%b src=%0d", c, req_ready, wr_en, wr_src);
        end
        wr_stall = 1'b0;
        #1; model_eval();
        total++;
        if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL stall_release: ready=%b required=1000", req_ready);
        end
        tick();
        total++;
        if (wr_en !== 1'b1 || wr_src !== 2'd3 || wr_addr !== 5'd4) begin
            bad++; $display("FAIL stall_accept: en=%b src=%0d addr=%0d required 1/3/4", wr_en, wr_src, wr_addr);
        end
        req_valid = '0;
        #1; model_eval(); tick();
    endtask

    task automatic test_async_reset();
        req_valid = '1;
        #1; model_eval(); tick();
        #1; model_eval(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (wr_en !== 1'b0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL async_reset: wr_en=%b ready=%b required 0/0000", wr_en, req_ready);
        end
        $display("async reset: wr_en=%b ready=%b", wr_en, req_ready);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL async_ptr: ready=%b required=0001", req_ready);
        end
        req_valid = '0;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_random();
        logic [N-1:0] pend = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    a_q[i] = ($urandom_range(0, 5) == 0) ? AW'(ZR) : AW'($urandom);
                    d_q[i] = {$urandom, $urandom};
                end
            end
            pack();
            req_valid = pend;
            wr_stall = ($urandom_range(0, 3) == 0);
            #1; model_eval();
            total++;
            if (req_ready !== m_ready) begin
                bad++; $display("FAIL rand_ready cyc%0d: ready=%b required=%b", c, req_ready, m_ready);
            end
            if (m_ready != '0) pend[m_win] = 1'b0;
            tick();
            total++;
            if (wr_en !== m_en || wr_addr !== m_addr || wr_data !== m_data || int'(wr_src) != m_src) begin
                bad++; $display("FAIL rand_out cyc%0d: en=%b addr=%0d data=%h src=%0d required en=%b addr=%0d data=%h src=%0d",
                                c, wr_en, wr_addr, wr_data, wr_src, m_en, m_addr, m_data, m_src);
            end
            $display("rand cyc%0d: valid=%b stall=%b ready=%b en=%b src=%0d", c, req_valid, wr_stall, req_ready, wr_en, wr_src);
        end
        req_valid = '0;
        wr_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_sequence();
        test_single();
        test_zero_reg();
        test_stall();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
